// File: rtl/raw_window3x3.sv
// 3x3 raw Bayer neighbourhood generator: two line buffers plus a shifting window,
// emitting one registered window per interior pixel with its centre coordinate.
module raw_window3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CW     = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic [11:0]   iDATA,
  output logic [11:0]   oP_0,
  output logic [11:0]   oP_1,
  output logic [11:0]   oP_2,
  output logic [11:0]   oP_3,
  output logic [11:0]   oP_4,
  output logic [11:0]   oP_5,
  output logic [11:0]   oP_6,
  output logic [11:0]   oP_7,
  output logic [11:0]   oP_8,
  output logic          oX_LSB,
  output logic          oY_LSB,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oDVAL
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] x_q, y_q, x_d, y_d;
  logic [11:0]   lb1_q [WIDTH];
  logic [11:0]   lb2_q [WIDTH];
  logic [11:0]   p_q   [9];
  logic [AW-1:0] col;
  logic [11:0]   tap1, tap2;
  logic          accept, emit;

  // Pixels past the last line are dropped until the frame closes.
  assign accept = iFVAL & iDVAL & (y_q != CW'(HEIGHT));
  assign emit   = accept & (x_q >= CW'(2)) & (y_q >= CW'(2));
  assign col    = x_q[AW-1:0];
  assign tap1   = lb1_q[col];
  assign tap2   = lb2_q[col];

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!iFVAL) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (x_q == CW'(WIDTH - 1)) begin
        x_d = '0;
        y_d = y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Line buffers read the old value at the column, then age it by one row.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb2_q[col] <= lb1_q[col];
      lb1_q[col] <= iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
    end else if (accept) begin
      p_q[2] <= p_q[1];
      p_q[1] <= p_q[0];
      p_q[0] <= tap2;
      p_q[5] <= p_q[4];
      p_q[4] <= p_q[3];
      p_q[3] <= tap1;
      p_q[8] <= p_q[7];
      p_q[7] <= p_q[6];
      p_q[6] <= iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL  <= 1'b0;
      oX     <= '0;
      oY     <= '0;
      oX_LSB <= 1'b0;
      oY_LSB <= 1'b0;
    end else begin
      oDVAL <= emit;
      if (emit) begin
        oX     <= x_q - CW'(1);
        oY     <= y_q - CW'(1);
        oX_LSB <= ~x_q[0];
        oY_LSB <= ~y_q[0];
      end
    end
  end

  assign oP_0 = p_q[0];
  assign oP_1 = p_q[1];
  assign oP_2 = p_q[2];
  assign oP_3 = p_q[3];
  assign oP_4 = p_q[4];
  assign oP_5 = p_q[5];
  assign oP_6 = p_q[6];
  assign oP_7 = p_q[7];
  assign oP_8 = p_q[8];

endmodule

// File: tb/tb_raw_window3x3.sv
// Directed bench for raw_window3x3 on an 8x6 frame with pixel value base|(y*16+x);
// expected windows are built from that pixel formula and consumed by a negedge monitor.
module tb_raw_window3x3;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 11;
  localparam int EW = 2 * CW + 9 * 12;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iFVAL = 1'b0;
  logic          iDVAL = 1'b0;
  logic [11:0]   iDATA = '0;
  logic [11:0]   oP_0, oP_1, oP_2, oP_3, oP_4, oP_5, oP_6, oP_7, oP_8;
  logic          oX_LSB, oY_LSB, oDVAL;
  logic [CW-1:0] oX, oY;
  logic [11:0]   op [9];

  int total_cnt = 0;
  int bad_cnt   = 0;
  int strobes   = 0;
  logic mon_en  = 1'b0;
  logic [EW-1:0] exp_q[$];

  raw_window3x3 #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .oP_0(oP_0), .oP_1(oP_1), .oP_2(oP_2), .oP_3(oP_3), .oP_4(oP_4),
    .oP_5(oP_5), .oP_6(oP_6), .oP_7(oP_7), .oP_8(oP_8),
    .oX_LSB(oX_LSB), .oY_LSB(oY_LSB), .oX(oX), .oY(oY), .oDVAL(oDVAL)
  );

  assign op = '{oP_0, oP_1, oP_2, oP_3, oP_4, oP_5, oP_6, oP_7, oP_8};

  // clock / reset
  always #5 iCLK = ~iCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [11:0] pix(input logic [11:0] base, input int x, input int y);
    logic [11:0] v;
    v = 12'(y * 16 + x);
    return base | v;
  endfunction

  // Window around centre (cx,cy): P0/P3/P6 are the right column, P2/P5/P8 the left.
  task automatic push_win(input logic [11:0] base, input int cx, input int cy);
    logic [8:0][11:0] p;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r * 3 + c] = pix(base, cx + 1 - c, cy - 1 + r);
    exp_q.push_back({CW'(cx), CW'(cy), p});
  endtask

  task automatic push_ref(input logic [11:0] base, input int npix);
    for (int i = 0; i < npix; i++) begin
      if ((i / W) < H && (i % W) >= 2 && (i / W) >= 2) push_win(base, (i % W) - 1, (i / W) - 1);
    end
  endtask

  // driver tasks
  task automatic cyc(input logic f, input logic d, input logic [11:0] dat);
    iFVAL = f;
    iDVAL = d;
    iDATA = dat;
    @(posedge iCLK);
    #1;
  endtask

  task automatic send_pixels(input logic [11:0] base, input int first, input int npix, input bit gaps);
    for (int i = first; i < first + npix; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, 12'($urandom_range(0, 4095)));
      cyc(1'b1, 1'b1, pix(base, i % W, i / W));
    end
  endtask

  task automatic end_frame();
    cyc(1'b0, 1'b0, 12'h0);
    cyc(1'b0, 1'b0, 12'h0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dval"}, 32'(oDVAL), 0);
    chk({tag, "_x"}, 32'(oX), 0);
    chk({tag, "_y"}, 32'(oY), 0);
    chk({tag, "_lsb"}, 32'({oX_LSB, oY_LSB}), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_p%0d", tag, k), 32'(op[k]), 0);
  endtask

  // scoreboard
  always @(negedge iCLK) begin
    if (oDVAL) begin
      strobes++;
      if (mon_en) begin
        chk("q_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [EW-1:0] e;
          logic [CW-1:0] ex, ey;
          logic [8:0][11:0] ep;
          e = exp_q.pop_front();
          {ex, ey, ep} = e;
          chk("ox", 32'(oX), 32'(ex));
          chk("oy", 32'(oY), 32'(ey));
          chk("x_lsb", 32'(oX_LSB), 32'(ex[0]));
          chk("y_lsb", 32'(oY_LSB), 32'(ey[0]));
          for (int k = 0; k < 9; k++) chk($sformatf("p%0d", k), 32'(op[k]), 32'(ep[k]));
        end
      end
    end
  end

  initial begin
    int s0;
    logic [11:0] snap [9];

    #23;
    chk_zero_outputs("por");
    @(negedge iCLK);
    iRST = 1'b0;
    mon_en = 1'b1;

    // Idle with frame open: no strobes.
    s0 = strobes;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 12'hfff);
    chk("idle_strobes", 32'(strobes - s0), 0);
    end_frame();

    // Continuous full frame.
    push_ref(12'h000, W * H);
    s0 = strobes;
    send_pixels(12'h000, 0, W * H, 1'b0);
    end_frame();
    chk("cont_strobes", 32'(strobes - s0), 24);
    chk("cont_drained", 32'(exp_q.size()), 0);

    // Same frame with random iDVAL gaps.
    push_ref(12'h000, W * H);
    s0 = strobes;
    send_pixels(12'h000, 0, W * H, 1'b1);
    end_frame();
    chk("gap_strobes", 32'(strobes - s0), 24);
    chk("gap_drained", 32'(exp_q.size()), 0);

    // 3.5 lines of a marked frame, then iFVAL low and a fresh frame.
    push_ref(12'h800, 3 * W + W / 2);
    send_pixels(12'h800, 0, 3 * W + W / 2, 1'b0);
    end_frame();
    chk("part_drained", 32'(exp_q.size()), 0);
    push_ref(12'h000, W * H);
    s0 = strobes;
    send_pixels(12'h000, 0, 2 * W, 1'b0);
    chk("fresh_rows01_strobes", 32'(strobes - s0), 0);
    send_pixels(12'h000, 2 * W, (H - 2) * W, 1'b0);
    end_frame();
    chk("fresh_strobes", 32'(strobes - s0), 24);
    chk("fresh_drained", 32'(exp_q.size()), 0);

    // Seven rows with HEIGHT=6: the extra row is ignored.
    push_ref(12'h000, W * H);
    s0 = strobes;
    send_pixels(12'h000, 0, W * H, 1'b0);
    for (int k = 0; k < 9; k++) snap[k] = op[k];
    chk("row6_last_p4", 32'(op[4]), 32'h046);
    send_pixels(12'h000, W * H, W, 1'b0);
    for (int k = 0; k < 9; k++) chk($sformatf("row6_hold_p%0d", k), 32'(op[k]), 32'(snap[k]));
    end_frame();
    chk("row7_strobes", 32'(strobes - s0), 24);
    chk("row7_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-frame, then the next data starts at (0,0).
    mon_en = 1'b0;
    send_pixels(12'h400, 0, 3 * W + 3, 1'b0);
    #2;
    iRST = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge iCLK);
    iRST = 1'b0;
    mon_en = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 12'h0);
    chk("post_rst_idle", 32'(strobes - s0), 0);
    push_ref(12'h000, W * H);
    send_pixels(12'h000, 0, W * H, 1'b0);
    end_frame();
    chk("post_rst_strobes", 32'(strobes - s0), 24);
    chk("post_rst_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/raw_window3x3.md
# raw_window3x3

Upstream neighbour of the Bayer-to-gray converter. Accepts the 12-bit raw Bayer pixel stream from the sensor capture path in raster order and buffers two prior lines. For every interior pixel it presents the 3x3 neighbourhood in the converter's P0..P8 layout, together with the centre coordinate parity bits. Outputs are registered and qualified by oDVAL; border pixels (outer row/column ring) are not emitted.

## Interface
- WIDTH, 640, active pixels per line (>=3)
- HEIGHT, 480, active lines per frame (>=3)
- CW, 11, coordinate counter width (2^CW > max(WIDTH, HEIGHT))
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iFVAL  in  1  frame valid; low clears position counters
- iDVAL  in  1  input pixel valid (one pixel accepted per cycle when iFVAL & iDVAL)
- iDATA  in  12  raw Bayer pixel
- oP_0 .. oP_8  out  12 each  window: row above = P2|P1|P0 (left..right), centre row = P5|P4|P3, row below = P8|P7|P6
- oX_LSB, oY_LSB  out  1  bit 0 of centre x / y
- oX, oY  out  CW  centre coordinate
- oDVAL  out  1  one-cycle strobe: window outputs valid

## Operation
- Counters x (column) and y (row) of the next input pixel, both start at 0.
- On accept (iFVAL & iDVAL): x increments; at x = WIDTH-1, x wraps to 0 and y increments. When y = HEIGHT, further accepted pixels are ignored: no buffer writes, no window shift, no oDVAL, until iFVAL goes low.
- iFVAL low: x, y <= 0. Line buffer and window contents are retained and not cleared.
- Two line buffers of WIDTH x 12, indexed by x. On accept at column x: tap1 = LB1[x] (row y-1), tap2 = LB2[x] (row y-2). LB2[x] <= LB1[x] and LB1[x] <= iDATA. Reads return the pre-write value (read-before-write). Either register arrays or RAM with old-data read-during-write is acceptable.
- Window shift on accept, new column enters on the right:
  - P2<=P1, P1<=P0, P0<=tap2
  - P5<=P4, P4<=P3, P3<=tap1
  - P8<=P7, P7<=P6, P6<=iDATA
- Window registers drive oP_* directly and hold between accepts.
- On accept with x >= 2 and y >= 2 (before increment), oDVAL <= 1, oX <= x-1, oY <= y-1, oX_LSB/oY_LSB <= bit 0 of those values. Otherwise oDVAL <= 0 and oX/oY hold.
- The gate guarantees every emitted tap was written in the current frame, so stale buffer data never reaches a valid output.
- Output per frame: (WIDTH-2) x (HEIGHT-2) strobes in raster order of centre coordinate.
- Parity convention: centre (even, even) = green with red above/below; (odd, even) = blue; (even, odd) = red; (odd, odd) = green with blue above/below.

## Timing
- Reset (async assert, outputs change without a clock): oP_* = 0, oDVAL = 0, oX = oY = 0, oX_LSB = oY_LSB = 0; x = y = 0. Line buffer contents undefined.
- Latency: the window completed by the pixel accepted in cycle N is on outputs in cycle N+1. oDVAL is high for exactly that cycle.
- Throughput: 1 pixel/cycle. No back-pressure; gaps in iDVAL stall the pipeline without loss.
- Reset mid-line/mid-frame: all state returns to reset values. The next data is treated as row 0, col 0 once iRST is low. The first valid window needs two full new rows.
- iFVAL dropping mid-line: the partial line is abandoned and the next accept is (0,0). An accept in the same cycle that iFVAL is low is not possible by definition.
- Wrap: the accept at x = WIDTH-1 may itself produce oDVAL (centre x = WIDTH-2) and wraps x in the same cycle.

## Test plan
- Reset: assert iRST mid-stream with no clock edge -> all outputs 0 immediately. After release, hold iFVAL=1 with iDVAL=0 -> oDVAL stays 0.
- Full frame, WIDTH=8, HEIGHT=6, iDATA = y*16+x, continuous iDVAL.
  - First oDVAL occurs one cycle after accepting (2,2), with oX=1, oY=1, oX_LSB=1, oY_LSB=1.
  - Window values: oP_4=0x011, oP_0=0x002, oP_2=0x000, oP_6=0x022, oP_8=0x020.
  - Total strobe count = 24; last strobe has oX=6, oY=4, oP_4=0x046.
- Same frame with pseudo-random iDVAL gaps (about 50% duty) -> identical sequence of (oX, oY, oP_0..oP_8) to the continuous run.
- iFVAL low after 3.5 lines, then a fresh 8x6 frame -> no oDVAL during the new frame's rows 0-1. The new frame's output matches the continuous-run reference exactly, with no stale data.
- 7 rows supplied with HEIGHT=6 -> exactly 24 strobes. Row 6 pixels cause no oDVAL and do not change oP_*.
- Boundary: accept at x=7, y=3 -> oDVAL with oX=6, oY=2, oP_0=0x017. The next accept (0,4) produces no oDVAL.
